// File: rtl/spi_flash_arbiter.sv
`timescale 1ns/1ps
// spi_flash_arbiter: hands the SPI config flash between the 6809 SPI master and the FT2232 programming port
module spi_flash_arbiter #(
  parameter int SYNC_STAGES     = 2,
  parameter int CPU_IDLE_CYCLES = 4,
  parameter int HALT_TIMEOUT    = 1024,
  parameter int RESET_HOLD      = 16
) (
  input  logic       i_CLK,
  input  logic       i_RST_N,
  input  logic       i_FT_CS,
  input  logic       i_CPU_SPI_CS,
  input  logic       i_CPU_BA,
  input  logic       i_CPU_BS,
  output logic       o_GRANT_FT,
  output logic       o_GRANT_CPU,
  output logic       o_FT_READY,
  output logic       o_HALT,
  output logic       o_RESET,
  output logic       o_FAULT,
  output logic [2:0] o_STATE
);
  localparam int IW = CPU_IDLE_CYCLES > 1 ? $clog2(CPU_IDLE_CYCLES) : 1;
  localparam int TW = HALT_TIMEOUT > 1 ? $clog2(HALT_TIMEOUT) : 1;
  localparam int HW = RESET_HOLD > 1 ? $clog2(RESET_HOLD) : 1;
  localparam logic [IW-1:0] IDLE_MAX = IW'(CPU_IDLE_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(HALT_TIMEOUT - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(RESET_HOLD - 1);

  typedef enum logic [2:0] {
    CPU_OWN  = 3'd0,
    WAIT_CPU = 3'd1,
    HALT_REQ = 3'd2,
    FT_OWN   = 3'd3,
    RELEASE  = 3'd4
  } state_t;

  state_t state, state_n;
  logic [SYNC_STAGES-1:0] ft_sr, cpu_sr, ba_sr, bs_sr;
  logic [IW-1:0] idle_cnt;
  logic [TW-1:0] to_cnt;
  logic [HW-1:0] hold_cnt;
  logic ft_req, cpu_cs_s, ack, timeout;

  assign ft_req   = !ft_sr[SYNC_STAGES-1];
  assign cpu_cs_s = cpu_sr[SYNC_STAGES-1];
  assign ack      = ba_sr[SYNC_STAGES-1] && bs_sr[SYNC_STAGES-1];
  assign timeout  = state == HALT_REQ && ft_req && !ack && to_cnt == TO_MAX;
  assign o_STATE  = state;

  // Synchronizers for the asynchronous inputs, reset to their inactive levels
  always_ff @(posedge i_CLK or negedge i_RST_N)
    if (!i_RST_N) begin
      ft_sr  <= '1;
      cpu_sr <= '1;
      ba_sr  <= '0;
      bs_sr  <= '0;
    end else begin
      ft_sr  <= {ft_sr[SYNC_STAGES-2:0], i_FT_CS};
      cpu_sr <= {cpu_sr[SYNC_STAGES-2:0], i_CPU_SPI_CS};
      ba_sr  <= {ba_sr[SYNC_STAGES-2:0], i_CPU_BA};
      bs_sr  <= {bs_sr[SYNC_STAGES-2:0], i_CPU_BS};
    end

  // Next-state: abort on request loss takes priority, ack beats a simultaneous timeout
  always_comb begin
    state_n = state;
    case (state)
      CPU_OWN:  state_n = ft_req ? WAIT_CPU : CPU_OWN;
      WAIT_CPU: state_n = !ft_req ? CPU_OWN : (cpu_cs_s && idle_cnt == IDLE_MAX) ? HALT_REQ : WAIT_CPU;
      HALT_REQ: state_n = !ft_req ? RELEASE : ack ? FT_OWN : to_cnt == TO_MAX ? RELEASE : HALT_REQ;
      FT_OWN:   state_n = ft_req ? FT_OWN : RELEASE;
      RELEASE:  state_n = hold_cnt == HOLD_MAX ? CPU_OWN : RELEASE;
      default:  state_n = RELEASE;
    endcase
  end

  // State register and saturating per-state counters, each cleared outside its own state
  always_ff @(posedge i_CLK or negedge i_RST_N)
    if (!i_RST_N) begin
      state    <= CPU_OWN;
      idle_cnt <= '0;
      to_cnt   <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      idle_cnt <= (state != WAIT_CPU || !cpu_cs_s) ? '0 : idle_cnt == IDLE_MAX ? idle_cnt : idle_cnt + IW'(1);
      to_cnt   <= state != HALT_REQ ? '0 : to_cnt == TO_MAX ? to_cnt : to_cnt + TW'(1);
      hold_cnt <= state != RELEASE ? '0 : hold_cnt == HOLD_MAX ? hold_cnt : hold_cnt + HW'(1);
    end

  // Outputs registered from the next state so they change on the entry edge
  always_ff @(posedge i_CLK or negedge i_RST_N)
    if (!i_RST_N) begin
      o_GRANT_CPU <= 1'b1;
      o_GRANT_FT  <= 1'b0;
      o_FT_READY  <= 1'b0;
      o_HALT      <= 1'b0;
      o_RESET     <= 1'b0;
      o_FAULT     <= 1'b0;
    end else begin
      o_GRANT_CPU <= state_n == CPU_OWN || state_n == WAIT_CPU;
      o_GRANT_FT  <= state_n == FT_OWN;
      o_FT_READY  <= state_n == FT_OWN;
      o_HALT      <= state_n == HALT_REQ || state_n == FT_OWN;
      o_RESET     <= state_n == RELEASE;
      o_FAULT     <= o_FAULT || timeout;
    end
endmodule
